spdif_bmc_serializer: RTL and testbench

Consumes 32-bit AES3/S/PDIF subframe words from the subframe formatter stage and drives the biphase-mark-coded serial line. Sits directly downstream of the formatter in the `clk_tx` domain. Holds one word in a skid register while the previous one is shifted out. Recomputes parity and substitutes invalid subframes on underrun so the line never stalls.

---
 rtl/spdif_bmc_serializer.sv | 190 +++++++++++++++++++
 tb/tb_spdif_bmc_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_bmc_serializer.sv
// spdif_bmc_serializer
// Takes 32-bit AES3/S/PDIF subframe words through a one-word hold register
// and drives them onto a biphase-mark-coded line. The line never stalls:
// when no word is waiting at a subframe boundary, an invalid (V=1) silent
// subframe is sent instead and the sticky underrun flag is raised.
module spdif_bmc_serializer #(
  parameter int UI_DIV = 4
) (
  input  logic        clk_tx,
  input  logic        reset_tx,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  input  logic        id_in,
  output logic        ready_in,
  output logic        spdif_out,
  output logic        subframe_start,
  output logic        underrun
);

  localparam int CW = (UI_DIV > 2) ? $clog2(UI_DIV) : 1;
  localparam logic [CW-1:0] CntMax = CW'(UI_DIV - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] uiCnt_q, uiCnt_d;
  logic [5:0]  uiIdx_q, uiIdx_d;
  logic [31:0] holdData_q, holdData_d;
  logic        holdId_q, holdId_d;
  logic        holdFull_q, holdFull_d;
  logic [31:0] word_q, word_d;
  logic        expId_q, expId_d;
  logic        l0_q, l0_d;
  logic        firstLoad_q, firstLoad_d;
  logic        spdif_q, spdif_d;
  logic        start_q, start_d;
  logic        underrun_q, underrun_d;

  logic        uiTick;
  logic        load;
  logic        transfer;
  logic [31:0] loadWord;
  logic [31:0] curWord;
  logic        curL0;
  logic [5:0]  nextIdx;
  logic [7:0]  pattern;
  logic        lineNext;

  // Normalises the preamble code to 1..3 using the channel id and inserts
  // even parity over bits 30:4; the incoming bit 31 is discarded.
  function automatic logic [31:0] fixWord(input logic [31:0] w, input logic id);
    logic [3:0] code;
    code = w[3:0];
    if ((code == 4'd0) || (code > 4'd3)) begin
      code = id ? 4'd3 : 4'd2;
    end
    return {^w[30:4], w[30:4], code};
  endfunction

  // Preamble shapes for starting level 0, first UI in the MSB.
  function automatic logic [7:0] patternOf(input logic [3:0] code);
    logic [7:0] p;
    case (code)
      4'd1:    p = 8'b11101000;
      4'd2:    p = 8'b11100010;
      default: p = 8'b11100100;
    endcase
    return p;
  endfunction

  assign ready_in       = ~holdFull_q & ~reset_tx;
  assign spdif_out      = spdif_q;
  assign subframe_start = start_q;
  assign underrun       = underrun_q;

  // Next-state, hold register, subframe loading and BMC line generation
  always_comb begin
    state_d     = state_q;
    uiCnt_d     = uiCnt_q;
    uiIdx_d     = uiIdx_q;
    holdData_d  = holdData_q;
    holdId_d    = holdId_q;
    holdFull_d  = holdFull_q;
    word_d      = word_q;
    expId_d     = expId_q;
    l0_d        = l0_q;
    firstLoad_d = firstLoad_q;
    spdif_d     = spdif_q;
    start_d     = 1'b0;
    underrun_d  = underrun_q;

    uiTick   = (state_q == RUN) && (uiCnt_q == CntMax);
    load     = uiTick && (firstLoad_q || (uiIdx_q == 6'd63));
    transfer = valid_in && ready_in;

    if (holdFull_q) begin
      loadWord = fixWord(holdData_q, holdId_q);
    end else begin
      loadWord = fixWord({4'b0001, 24'h000000, (expId_q ? 4'd3 : 4'd2)}, expId_q);
    end

    curWord = load ? loadWord : word_q;
    curL0   = load ? spdif_q : l0_q;
    nextIdx = load ? 6'd0 : (uiIdx_q + 6'd1);
    pattern = patternOf(curWord[3:0]);

    if (nextIdx < 6'd8) begin
      lineNext = pattern[~nextIdx[2:0]] ^ curL0;
    end else if (!nextIdx[0]) begin
      lineNext = ~spdif_q;
    end else begin
      lineNext = curWord[nextIdx[5:1]] ? ~spdif_q : spdif_q;
    end

    if (load) begin
      holdFull_d = 1'b0;
    end
    if (transfer) begin
      holdFull_d = 1'b1;
      holdData_d = data_in;
      holdId_d   = id_in;
    end

    case (state_q)
      IDLE: begin
        uiCnt_d     = '0;
        uiIdx_d     = 6'd0;
        spdif_d     = 1'b0;
        firstLoad_d = 1'b1;
        if (holdFull_q) begin
          state_d = RUN;
        end
      end
      default: begin
        uiCnt_d = uiTick ? '0 : (uiCnt_q + CW'(1));
        if (uiTick) begin
          uiIdx_d = nextIdx;
          spdif_d = lineNext;
        end
        if (load) begin
          word_d      = loadWord;
          l0_d        = spdif_q;
          expId_d     = firstLoad_q ? ~holdId_q : ~expId_q;
          firstLoad_d = 1'b0;
          start_d     = 1'b1;
          if (!holdFull_q) begin
            underrun_d = 1'b1;
          end
        end
      end
    endcase
  end

  // State register with synchronous reset; reset drops any partial subframe
  always_ff @(posedge clk_tx) begin
    if (reset_tx) begin
      state_q     <= IDLE;
      uiCnt_q     <= '0;
      uiIdx_q     <= 6'd0;
      holdData_q  <= 32'h0;
      holdId_q    <= 1'b0;
      holdFull_q  <= 1'b0;
      word_q      <= 32'h0;
      expId_q     <= 1'b0;
      l0_q        <= 1'b0;
      firstLoad_q <= 1'b1;
      spdif_q     <= 1'b0;
      start_q     <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      uiCnt_q     <= uiCnt_d;
      uiIdx_q     <= uiIdx_d;
      holdData_q  <= holdData_d;
      holdId_q    <= holdId_d;
      holdFull_q  <= holdFull_d;
      word_q      <= word_d;
      expId_q     <= expId_d;
      l0_q        <= l0_d;
      firstLoad_q <= firstLoad_d;
      spdif_q     <= spdif_d;
      start_q     <= start_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_spdif_bmc_serializer.sv
// Testbench for spdif_bmc_serializer: directed and random subframe words,
// each emitted subframe compared UI by UI against a reference line built
// from the biphase-mark rules.
module tb_spdif_bmc_serializer;

  localparam int UiDiv     = 4;
  localparam int SubCycles = 64 * UiDiv;

  logic        clk_tx   = 1'b0;
  logic        reset_tx = 1'b1;
  logic [31:0] data_in  = 32'h0;
  logic        valid_in = 1'b0;
  logic        id_in    = 1'b0;
  logic        ready_in;
  logic        spdif_out;
  logic        subframe_start;
  logic        underrun;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [31:0] stimWords[$];
  logic        stimIds[$];
  logic [31:0] refWords[$];
  logic        refIds[$];

  logic modelL0;
  logic modelExpId;
  logic modelFirst;
  logic modelUnderrun;

  spdif_bmc_serializer #(.UI_DIV(UiDiv)) dut (
    .clk_tx         (clk_tx),
    .reset_tx       (reset_tx),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .id_in          (id_in),
    .ready_in       (ready_in),
    .spdif_out      (spdif_out),
    .subframe_start (subframe_start),
    .underrun       (underrun)
  );

  // Free-running clock
  always #5 clk_tx = ~clk_tx;

  // Cycle counter used to measure spacing between subframe starts
  always @(posedge clk_tx) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference line for one subframe: bit k of the result is UI k.
  // Preamble is the fixed shape inverted when the line starts high; each data
  // cell begins with a level change and bit value 1 adds a mid-cell change.
  function automatic logic [63:0] expectLine(input logic [31:0] w, input logic id, input logic l0);
    logic [63:0] ui;
    logic [7:0]  pat;
    logic [3:0]  code;
    logic        lvl;
    logic        b;
    int          ones;
    code = w[3:0];
    if (code == 0 || code >= 4) code = id ? 4'd3 : 4'd2;
    case (code)
      4'd1:    pat = 8'b11101000;
      4'd2:    pat = 8'b11100010;
      default: pat = 8'b11100100;
    endcase
    ui = '0;
    for (int k = 0; k < 8; k++) ui[k] = pat[7-k] ^ l0;
    ones = 0;
    for (int s = 4; s <= 30; s++) if (w[s]) ones++;
    lvl = ui[7];
    for (int s = 4; s <= 31; s++) begin
      b = (s == 31) ? ((ones % 2) == 1) : w[s];
      lvl = ~lvl;
      ui[2*s] = lvl;
      if (b) lvl = ~lvl;
      ui[2*s+1] = lvl;
    end
    return ui;
  endfunction

  task automatic resetModel();
    modelL0       = 1'b0;
    modelExpId    = 1'b0;
    modelFirst    = 1'b1;
    modelUnderrun = 1'b0;
  endtask

  task automatic addWord(input logic [31:0] w, input logic id);
    stimWords.push_back(w);
    stimIds.push_back(id);
    refWords.push_back(w);
    refIds.push_back(id);
  endtask

  // Upstream producer: offers each word and holds it until accepted
  task automatic applyStimulus();
    int n;
    n = stimWords.size();
    for (int i = 0; i < n; i++) begin
      int guard;
      guard = 0;
      @(negedge clk_tx);
      data_in  = stimWords[i];
      id_in    = stimIds[i];
      valid_in = 1'b1;
      while (!ready_in && guard < 2 * SubCycles) begin
        @(negedge clk_tx);
        guard++;
      end
      checkOutput($sformatf("ready_wait_%0d", i), ready_in, 1);
      @(posedge clk_tx);
    end
    @(negedge clk_tx);
    valid_in = 1'b0;
    stimWords.delete();
    stimIds.delete();
  endtask

  // Watches a run of subframes and compares each against the reference model
  task automatic checkSubframes(input int total, input int nReal);
    int lastStart;
    lastStart = 0;
    for (int n = 0; n < total; n++) begin
      int guard, readyHigh, starts, glitch;
      logic [63:0] got, exp;
      logic [31:0] w;
      logic        id;
      guard = 0; readyHigh = 0; starts = 0; glitch = 0; got = '0;
      while (!subframe_start && guard < 4 * SubCycles) begin
        @(negedge clk_tx);
        guard++;
      end
      checkOutput($sformatf("start_seen_%0d", n), subframe_start, 1);
      if (n > 0) checkOutput($sformatf("start_spacing_%0d", n), cycle - lastStart, SubCycles);
      lastStart = cycle;

      if (refWords.size() > 0) begin
        w  = refWords.pop_front();
        id = refIds.pop_front();
        if (modelFirst) modelExpId = id;
      end else begin
        w  = {4'b0001, 24'h000000, (modelExpId ? 4'd3 : 4'd2)};
        id = modelExpId;
        modelUnderrun = 1'b1;
      end
      modelFirst = 1'b0;
      modelExpId = ~modelExpId;
      exp     = expectLine(w, id, modelL0);
      modelL0 = exp[63];

      for (int c = 0; c < SubCycles; c++) begin
        if (c % UiDiv == 0) got[c / UiDiv] = spdif_out;
        else if (spdif_out !== got[c / UiDiv]) glitch++;
        if (ready_in) readyHigh++;
        if (subframe_start) starts++;
        if (c == 0) checkOutput($sformatf("underrun_%0d", n), underrun, modelUnderrun);
        @(negedge clk_tx);
      end
      checkOutput($sformatf("line_%0d", n), got, exp);
      checkOutput($sformatf("end_level_%0d", n), got[63], 0);
      checkOutput($sformatf("ui_stable_%0d", n), glitch, 0);
      checkOutput($sformatf("start_pulses_%0d", n), starts, 1);
      checkOutput($sformatf("ready_cycles_%0d", n), readyHigh, (n < nReal - 1) ? 1 : SubCycles);
    end
  endtask

  initial begin
    int bad;

    // Reset behaviour
    reset_tx = 1'b1;
    @(negedge clk_tx);
    @(negedge clk_tx);
    checkOutput("reset_ready", ready_in, 0);
    checkOutput("reset_line", spdif_out, 0);
    checkOutput("reset_start", subframe_start, 0);
    checkOutput("reset_underrun", underrun, 0);
    reset_tx = 1'b0;
    @(negedge clk_tx);
    checkOutput("post_reset_ready", ready_in, 1);

    // Idle with no data: line quiet, no pulses, no underrun
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (spdif_out !== 1'b0 || ready_in !== 1'b1 || underrun !== 1'b0 || subframe_start !== 1'b0) bad++;
      @(negedge clk_tx);
    end
    checkOutput("idle_bad_cycles", bad, 0);

    // Directed and random words streamed back to back, then underrun
    $display("[TB] streaming 10 words");
    resetModel();
    addWord(32'h00000001, 1'b0);
    addWord(32'h0FFFFFF2, 1'b1);
    addWord(32'h0FFFFFF3, 1'b0);
    addWord(32'h00000011, 1'b1);
    for (int i = 0; i < 6; i++) addWord($urandom, 1'($urandom_range(0, 1)));
    fork
      applyStimulus();
      checkSubframes(12, 10);
    join

    // Reset in the middle of a subframe: UI0 of the preamble is high here
    checkOutput("pre_reset_line", spdif_out, 1);
    reset_tx = 1'b1;
    @(negedge clk_tx);
    checkOutput("midreset_line", spdif_out, 0);
    checkOutput("midreset_start", subframe_start, 0);
    reset_tx = 1'b0;
    @(negedge clk_tx);
    checkOutput("midreset_ready", ready_in, 1);
    checkOutput("midreset_underrun", underrun, 0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      if (spdif_out !== 1'b0 || subframe_start !== 1'b0) bad++;
      @(negedge clk_tx);
    end
    checkOutput("midreset_idle_bad", bad, 0);

    // Three words then starvation: substitutes alternate the channel
    $display("[TB] three words then underrun");
    resetModel();
    for (int i = 0; i < 3; i++) addWord($urandom, 1'($urandom_range(0, 1)));
    fork
      applyStimulus();
      checkSubframes(5, 3);
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
